// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag index and FSM state definitions shared by the sequential ALU
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADC = 4'd0,
    ALU_SBC = 4'd1,
    ALU_AND = 4'd2,
    ALU_ORA = 4'd3,
    ALU_EOR = 4'd4,
    ALU_ASL = 4'd5,
    ALU_LSR = 4'd6,
    ALU_ROL = 4'd7,
    ALU_ROR = 4'd8,
    ALU_CMP = 4'd9
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DADJ = 2'd2,
    DONE = 2'd3
  } alu_state_e;

endpackage

// File: rtl/bcd_adjust.sv
// rtl/bcd_adjust.sv - per-digit BCD correction of a binary ADC/SBC result (built only with DECIMAL_MODE_EN)
`ifdef DECIMAL_MODE_EN
module bcd_adjust #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   i_sum,
  input  logic [WIDTH/4-1:0] i_dcarry,
  input  logic               i_sub,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_carry
);

  localparam int NDIG = WIDTH / 4;

  logic [WIDTH-1:0] w_res;
  logic [NDIG:0]    w_cy;
  logic [4:0]       w_t;

  // Addition ripples the +6 carry into the next digit; subtraction borrows never ripple.
  always_comb begin
    w_res = '0;
    w_cy  = '0;
    w_t   = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (i_sub) begin
        w_cy[i+1] = i_dcarry[i];
        w_res[4*i +: 4] = (!i_dcarry[i] || (i_sum[4*i +: 4] > 4'd9)) ?
                          i_sum[4*i +: 4] - 4'd6 : i_sum[4*i +: 4];
      end else begin
        w_t = {1'b0, i_sum[4*i +: 4]} + {4'b0000, w_cy[i]};
        w_cy[i+1] = i_dcarry[i] || (w_t > 5'd9);
        w_res[4*i +: 4] = w_cy[i+1] ? w_t[3:0] + 4'd6 : w_t[3:0];
      end
    end
  end

  assign o_result = w_res;
  assign o_carry  = w_cy[NDIG];

endmodule
`endif

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked multi-cycle 6502-style ALU with N/V/Z/C flag register
// DECIMAL_MODE_EN enables the DADJ state and BCD correction of ADC/SBC.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic             decimal,
  input  logic             flags_we,
  input  logic [3:0]       flags_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  alu_state_e       r_state, w_next;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_m, r_result;
  logic [3:0]       r_flags;

  logic             w_accept, w_sub, w_cin, w_dec_go;
  logic [WIDTH-1:0] w_mx, w_res, w_out, w_bcd_res;
  logic [WIDTH:0]   w_sum;
  logic [3:0]       w_flags, w_dflags;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_sub    = (r_op == ALU_SBC) || (r_op == ALU_CMP);
  assign w_mx     = w_sub ? ~r_m : r_m;
  assign w_cin    = (r_op == ALU_CMP) ? 1'b1 : r_flags[FLAG_C];
  assign w_sum    = {1'b0, r_a} + {1'b0, w_mx} + {{WIDTH{1'b0}}, w_cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = EXEC;
      EXEC:    w_next = w_dec_go ? DADJ : DONE;
      DADJ:    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // CMP flags come from the difference, but the delivered result is a.
  always_comb begin
    w_res   = '0;
    w_flags = r_flags;
    case (r_op)
      ALU_ADC, ALU_SBC: begin
        w_res           = w_sum[WIDTH-1:0];
        w_flags[FLAG_C] = w_sum[WIDTH];
        w_flags[FLAG_V] = (r_a[WIDTH-1] ^ w_sum[WIDTH-1]) & (w_mx[WIDTH-1] ^ w_sum[WIDTH-1]);
      end
      ALU_CMP: begin
        w_res           = w_sum[WIDTH-1:0];
        w_flags[FLAG_C] = w_sum[WIDTH];
      end
      ALU_AND: w_res = r_a & r_m;
      ALU_ORA: w_res = r_a | r_m;
      ALU_EOR: w_res = r_a ^ r_m;
      ALU_ASL: begin
        w_res           = {r_m[WIDTH-2:0], 1'b0};
        w_flags[FLAG_C] = r_m[WIDTH-1];
      end
      ALU_ROL: begin
        w_res           = {r_m[WIDTH-2:0], r_flags[FLAG_C]};
        w_flags[FLAG_C] = r_m[WIDTH-1];
      end
      ALU_LSR: begin
        w_res           = {1'b0, r_m[WIDTH-1:1]};
        w_flags[FLAG_C] = r_m[0];
      end
      ALU_ROR: begin
        w_res           = {r_flags[FLAG_C], r_m[WIDTH-1:1]};
        w_flags[FLAG_C] = r_m[0];
      end
      default: ;
    endcase
    if (r_op <= ALU_CMP) begin
      w_flags[FLAG_N] = w_res[WIDTH-1];
      w_flags[FLAG_Z] = (w_res == '0);
    end
  end

  assign w_out = (r_op == ALU_CMP) ? r_a : w_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_m      <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op <= op;
        r_a  <= a;
        r_m  <= m;
      end
      if (r_state == EXEC) r_result <= w_out;
      if (r_state == DADJ) r_result <= w_bcd_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_flags <= 4'b0000;
    else if (flags_we)                     r_flags <= flags_wdata;
    else if (r_state == EXEC && !w_dec_go) r_flags <= w_flags;
    else if (r_state == DADJ)              r_flags <= w_dflags;
  end

`ifdef DECIMAL_MODE_EN
  localparam int NDIG = WIDTH / 4;

  logic            r_dec, r_v, w_arith, w_bcd_c;
  logic [NDIG-1:0] r_dcarry, w_dcarry;

  // Digit carry-out of nibble g is the carry into bit 4g+4 of the binary sum.
  for (genvar g = 0; g < NDIG; g++) begin : g_dcarry
    if (g == NDIG - 1) begin : g_top
      assign w_dcarry[g] = w_sum[WIDTH];
    end else begin : g_mid
      assign w_dcarry[g] = w_sum[4*g+4] ^ r_a[4*g+4] ^ w_mx[4*g+4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec    <= 1'b0;
      r_v      <= 1'b0;
      r_dcarry <= '0;
    end else begin
      if (w_accept) r_dec <= decimal;
      if (r_state == EXEC) begin
        r_v      <= w_flags[FLAG_V];
        r_dcarry <= w_dcarry;
      end
    end
  end

  assign w_arith  = (r_op == ALU_ADC) || (r_op == ALU_SBC);
  assign w_dec_go = r_dec && w_arith;

  bcd_adjust #(.WIDTH(WIDTH)) u_bcd (
    .i_sum    (r_result),
    .i_dcarry (r_dcarry),
    .i_sub    (r_op == ALU_SBC),
    .o_result (w_bcd_res),
    .o_carry  (w_bcd_c)
  );

  always_comb begin
    w_dflags         = r_flags;
    w_dflags[FLAG_N] = w_bcd_res[WIDTH-1];
    w_dflags[FLAG_V] = r_v;
    w_dflags[FLAG_Z] = (w_bcd_res == '0);
    w_dflags[FLAG_C] = w_bcd_c;
  end
`else
  logic w_unused_decimal;
  assign w_unused_decimal = decimal;
  assign w_dec_go         = 1'b0;
  assign w_bcd_res        = '0;
  assign w_dflags         = r_flags;
`endif

  assign result = r_result;
  assign flags  = r_flags;

endmodule
